pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: LU_HAZ  in  1  load-use hazard detected in ID (EX holds LW whose rd matches an ID source).
REQ-004 SHALL have ports: BR_TAKEN  in  1  EX-stage redirect (taken branch/jump).
REQ-005 SHALL have ports: DMEM_REQ  in  1  MEM-stage instruction accesses data memory.
REQ-006 SHALL have ports: DMEM_ACK  in  1  data-memory access complete this cycle.
REQ-007 SHALL have ports: HALT_REQ  in  1  halt instruction retiring in WB.
REQ-008 SHALL have ports: PC_WE  out  1  PC write enable.
REQ-009 SHALL have ports: IFID_WE  out  1  IF/ID register enable.
REQ-010 SHALL have ports: IDEX_BUBBLE  out  1  load NOP into ID/EX.
REQ-011 SHALL have ports: FLUSH  out  2  bit0 flush IF/ID, bit1 flush ID/EX.
REQ-012 SHALL have ports: STALL  out  1  front end frozen this cycle.
REQ-013 SHALL have ports: PREV_STALL  out  1  STALL delayed one cycle (forwarding unit select).
REQ-014 SHALL have ports: HALTED  out  1  pipeline halted.
REQ-015 SHALL have ports: STATE  out  3  current state encoding (debug).

Function
REQ-016 SHALL implement FSM states RUN=0, LU=1, BR=2, MW=3, HLT=4; all outputs decoded from registered state and counters only (no input-to-output combinational path).
REQ-017 SHALL, in RUN: PC_WE=1, IFID_WE=1, IDEX_BUBBLE=0, FLUSH=00, STALL=0.
REQ-018 SHALL evaluate RUN exits with priority HALT_REQ > (DMEM_REQ & !DMEM_ACK) > BR_TAKEN > LU_HAZ; none asserted -> stay RUN.
REQ-019 SHALL hold LU exactly one cycle: PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1, STALL=1; next state RUN; LU_HAZ sampled in LU ignored (no back-to-back stall).
REQ-020 SHALL hold BR two cycles via 2-bit flush counter: cycle 1 FLUSH=11, cycle 2 FLUSH=01; PC_WE=1, IFID_WE=1, STALL=0; next state RUN.
REQ-021 SHALL ignore LU_HAZ and BR_TAKEN while in BR.
REQ-022 SHALL enter MW from RUN, LU or BR when DMEM_REQ=1 and DMEM_ACK=0; MW outputs PC_WE=0, IFID_WE=0, IDEX_BUBBLE=0, FLUSH=00, STALL=1.
REQ-023 SHALL leave MW on the cycle DMEM_ACK=1: resume BR with remaining flush count if MW was entered from BR with count nonzero, else RUN; an LU interrupted by MW is not replayed.
REQ-024 SHALL enter HLT on HALT_REQ from any state except MW (MW completes first); HLT: all enables 0, FLUSH=00, STALL=1, HALTED=1; HLT exits only by reset.
REQ-025 SHALL resolve BR_TAKEN and LU_HAZ in the same RUN cycle as BR (hazarding instruction is flushed).
REQ-026 SHALL register PREV_STALL <= STALL every cycle.
REQ-027 SHALL never assert IDEX_BUBBLE and FLUSH[1] together.

Reset
REQ-028 SHALL on RST=1, asynchronously: state RUN, flush counter 0, saved BR count 0, PREV_STALL=0, HALTED=0, perf counters 0.
REQ-029 SHALL abandon any in-progress LU/BR/MW on reset without completing it; first post-reset cycle is RUN.

Configuration
REQ-030 SHALL, with macro PIPE_CTRL_PERF_CNT_EN defined, add outputs STALL_CNT (32) and FLUSH_CNT (32): STALL_CNT +1 each cycle STALL=1 outside HLT, FLUSH_CNT +1 per BR entry, both wrap at 2^32.
REQ-031 SHALL, without PIPE_CTRL_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: LU_HAZ=1 one cycle in RUN -> next cycle STALL=1, IDEX_BUBBLE=1, PC_WE=0; cycle after RUN, PREV_STALL=1.
REQ-033 SHALL cover: BR_TAKEN=1 and LU_HAZ=1 same cycle -> FLUSH=11 then 01, STALL never 1, then RUN.
REQ-034 SHALL cover: DMEM_REQ=1, DMEM_ACK low 3 cycles -> STALL=1 for 3 cycles in MW, RUN on the ACK cycle's next edge.
REQ-035 SHALL cover: MW entered after BR cycle 1 -> after ACK, exactly one FLUSH=01 cycle, then RUN.
REQ-036 SHALL cover: HALT_REQ=1 -> HALTED=1 held through any inputs; RST mid-LU -> STATE=0, STALL=0 immediately.
REQ-037 SHALL cover (PIPE_CTRL_PERF_CNT_EN): two LU stalls plus one branch -> STALL_CNT=2, FLUSH_CNT=1.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Control bus between the hazard/stall controller and the datapath.
// With PIPE_CTRL_PERF_CNT_EN defined the bus also carries the perf counters.
interface pipe_ctrl_if;
  logic        LU_HAZ;
  logic        BR_TAKEN;
  logic        DMEM_REQ;
  logic        DMEM_ACK;
  logic        HALT_REQ;
  logic        PC_WE;
  logic        IFID_WE;
  logic        IDEX_BUBBLE;
  logic [1:0]  FLUSH;
  logic        STALL;
  logic        PREV_STALL;
  logic        HALTED;
  logic [2:0]  STATE;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] STALL_CNT;
  logic [31:0] FLUSH_CNT;
`endif

  modport master (
    output LU_HAZ, BR_TAKEN, DMEM_REQ, DMEM_ACK, HALT_REQ,
    input  PC_WE, IFID_WE, IDEX_BUBBLE, FLUSH, STALL, PREV_STALL, HALTED, STATE
`ifdef PIPE_CTRL_PERF_CNT_EN
    , input STALL_CNT, FLUSH_CNT
`endif
  );

  modport slave (
    input  LU_HAZ, BR_TAKEN, DMEM_REQ, DMEM_ACK, HALT_REQ,
    output PC_WE, IFID_WE, IDEX_BUBBLE, FLUSH, STALL, PREV_STALL, HALTED, STATE
`ifdef PIPE_CTRL_PERF_CNT_EN
    , output STALL_CNT, FLUSH_CNT
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait, halt.
// Optional perf counters (STALL_CNT, FLUSH_CNT) enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl (
  input  logic       CLK,
  input  logic       RST,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 2;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    S_RUN = 3'd0,
    S_LU  = 3'd1,
    S_BR  = 3'd2,
    S_MW  = 3'd3,
    S_HLT = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic [CNT_W-1:0] saved_cnt, saved_cnt_nxt;
  logic             prev_stall;
  logic             br_entry_c;
  logic             mem_wait_c;

  logic             pc_we_c;
  logic             ifid_we_c;
  logic             bubble_c;
  logic [1:0]       flush_c;
  logic             stall_c;
  logic             halted_c;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_RUN;
      flush_cnt  <= '0;
      saved_cnt  <= '0;
      prev_stall <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_cnt  <= flush_cnt_nxt;
      saved_cnt  <= saved_cnt_nxt;
      prev_stall <= stall_c;
    end
  end

  assign mem_wait_c = bus.DMEM_REQ & ~bus.DMEM_ACK;

  // Next-state logic; halt wins everywhere except an outstanding memory access
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    saved_cnt_nxt = saved_cnt;
    br_entry_c    = 1'b0;
    case (state)
      S_RUN: begin
        if (bus.HALT_REQ) begin
          state_nxt = S_HLT;
        end else if (mem_wait_c) begin
          state_nxt     = S_MW;
          saved_cnt_nxt = '0;
        end else if (bus.BR_TAKEN) begin
          state_nxt     = S_BR;
          flush_cnt_nxt = CNT_W'(2);
          br_entry_c    = 1'b1;
        end else if (bus.LU_HAZ) begin
          state_nxt = S_LU;
        end
      end
      S_LU: begin
        if (bus.HALT_REQ) begin
          state_nxt = S_HLT;
        end else if (mem_wait_c) begin
          state_nxt     = S_MW;
          saved_cnt_nxt = '0;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_BR: begin
        if (bus.HALT_REQ) begin
          state_nxt     = S_HLT;
          flush_cnt_nxt = '0;
        end else if (mem_wait_c) begin
          // This cycle's flush still happens; park only what remains after it
          state_nxt     = S_MW;
          saved_cnt_nxt = CNT_W'(flush_cnt - CNT_W'(1));
          flush_cnt_nxt = '0;
        end else if (flush_cnt == CNT_W'(2)) begin
          flush_cnt_nxt = CNT_W'(1);
        end else begin
          state_nxt     = S_RUN;
          flush_cnt_nxt = '0;
        end
      end
      S_MW: begin
        if (bus.DMEM_ACK) begin
          saved_cnt_nxt = '0;
          if (saved_cnt != '0) begin
            state_nxt     = S_BR;
            flush_cnt_nxt = saved_cnt;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_HLT:   state_nxt = S_HLT;
      default: state_nxt = S_RUN;
    endcase
  end

  // Moore output decode from registered state and flush counter
  always_comb begin
    pc_we_c   = 1'b0;
    ifid_we_c = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 2'b00;
    stall_c   = 1'b0;
    halted_c  = 1'b0;
    case (state)
      S_RUN: begin
        pc_we_c   = 1'b1;
        ifid_we_c = 1'b1;
      end
      S_LU: begin
        bubble_c = 1'b1;
        stall_c  = 1'b1;
      end
      S_BR: begin
        pc_we_c   = 1'b1;
        ifid_we_c = 1'b1;
        flush_c   = (flush_cnt == CNT_W'(2)) ? 2'b11 :
                    (flush_cnt == CNT_W'(1)) ? 2'b01 : 2'b00;
      end
      S_MW:  stall_c = 1'b1;
      S_HLT: begin
        stall_c  = 1'b1;
        halted_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.PC_WE       = pc_we_c;
  assign bus.IFID_WE     = ifid_we_c;
  assign bus.IDEX_BUBBLE = bubble_c;
  assign bus.FLUSH       = flush_c;
  assign bus.STALL       = stall_c;
  assign bus.PREV_STALL  = prev_stall;
  assign bus.HALTED      = halted_c;
  assign bus.STATE       = state;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam int unsigned PERF_W = 32;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt_perf;

  // Halt cycles are not counted as stalls; counters wrap naturally
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt      <= '0;
      flush_cnt_perf <= '0;
    end else begin
      if (stall_c && (state != S_HLT)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (br_entry_c) flush_cnt_perf <= flush_cnt_perf + PERF_W'(1);
    end
  end

  assign bus.STALL_CNT = stall_cnt;
  assign bus.FLUSH_CNT = flush_cnt_perf;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes hand-computed expectations, monitor compares.
module tb_pipe_ctrl;
  localparam logic [2:0] RUN = 3'd0;
  localparam logic [2:0] LU  = 3'd1;
  localparam logic [2:0] BR  = 3'd2;
  localparam logic [2:0] MW  = 3'd3;
  localparam logic [2:0] HLT = 3'd4;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic       pc;
    logic       ifid;
    logic       bub;
    logic [1:0] fl;
    logic       stall;
    logic       ps;
    logic       halted;
  } exp_t;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  event ev_async;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected outputs per state from the output table; flush and prev_stall given by hand
  function automatic exp_t mk(input string nm, input logic [2:0] st, input logic [1:0] fl,
                              input logic ps);
    exp_t e;
    e.name = nm; e.st = st; e.fl = 2'b00; e.ps = ps;
    e.pc = 1'b0; e.ifid = 1'b0; e.bub = 1'b0; e.stall = 1'b0; e.halted = 1'b0;
    case (st)
      RUN: begin e.pc = 1'b1; e.ifid = 1'b1; end
      LU:  begin e.bub = 1'b1; e.stall = 1'b1; end
      BR:  begin e.pc = 1'b1; e.ifid = 1'b1; e.fl = fl; end
      MW:  e.stall = 1'b1;
      HLT: begin e.stall = 1'b1; e.halted = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic step(input string nm, input logic lu, input logic br, input logic req,
                      input logic ack, input logic halt, input logic [2:0] st,
                      input logic [1:0] fl, input logic ps);
    @(negedge CLK);
    bus.LU_HAZ   = lu;
    bus.BR_TAKEN = br;
    bus.DMEM_REQ = req;
    bus.DMEM_ACK = ack;
    bus.HALT_REQ = halt;
    exp_q.push_back(mk(nm, st, fl, ps));
  endtask

  // Monitor: compares one expectation per clock (or on an asynchronous reset event)
  initial begin
    exp_t       e;
    logic [10:0] got, want;
    forever begin
      @(posedge CLK or ev_async);
      #1;
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        got  = {bus.STATE, bus.PC_WE, bus.IFID_WE, bus.IDEX_BUBBLE, bus.FLUSH,
                bus.STALL, bus.PREV_STALL, bus.HALTED};
        want = {e.st, e.pc, e.ifid, e.bub, e.fl, e.stall, e.ps, e.halted};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s: got st/pc/ifid/bub/fl/stall/ps/halt=%b required %b", e.name, got, want);
        end
      end
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, got, want);
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    RST = 1'b1;
    bus.LU_HAZ = 1'b0; bus.BR_TAKEN = 1'b0; bus.DMEM_REQ = 1'b0;
    bus.DMEM_ACK = 1'b0; bus.HALT_REQ = 1'b0;
    #3;
    exp_q.push_back(mk("reset_state", RUN, 2'b00, 1'b0));
    -> ev_async;
`ifdef PIPE_CTRL_PERF_CNT_EN
    #2;
    chk32("reset_stall_cnt", bus.STALL_CNT, 32'd0);
    chk32("reset_flush_cnt", bus.FLUSH_CNT, 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;

    // name, lu, br, req, ack, halt -> state, flush, prev_stall
    step("idle",          0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("lu_enter",      1, 0, 0, 0, 0, LU,  2'b00, 0);
    step("lu_no_repeat",  1, 0, 0, 0, 0, RUN, 2'b00, 1);
    step("lu_after",      0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("lu2_enter",     1, 0, 0, 0, 0, LU,  2'b00, 0);
    step("lu2_exit",      0, 0, 0, 0, 0, RUN, 2'b00, 1);
    step("br_lu_c1",      1, 1, 0, 0, 0, BR,  2'b11, 0);
    step("br_lu_c2",      1, 1, 0, 0, 0, BR,  2'b01, 0);
    step("br_exit",       0, 0, 0, 0, 0, RUN, 2'b00, 0);
`ifdef PIPE_CTRL_PERF_CNT_EN
    @(posedge CLK); #2;
    chk32("perf_stall_cnt", bus.STALL_CNT, 32'd2);
    chk32("perf_flush_cnt", bus.FLUSH_CNT, 32'd1);
`endif
    step("mw_over_br",    0, 1, 1, 0, 0, MW,  2'b00, 0);
    step("mw_wait2",      0, 0, 1, 0, 0, MW,  2'b00, 1);
    step("mw_wait3_halt", 0, 0, 1, 0, 1, MW,  2'b00, 1);
    step("mw_ack",        0, 0, 1, 1, 0, RUN, 2'b00, 1);
    step("mw_after",      0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("brmw_c1",       0, 1, 0, 0, 0, BR,  2'b11, 0);
    step("brmw_wait",     0, 0, 1, 0, 0, MW,  2'b00, 0);
    step("brmw_resume",   0, 0, 1, 1, 0, BR,  2'b01, 1);
    step("brmw_run",      0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("brmw_idle",     0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("lumw_lu",       1, 0, 0, 0, 0, LU,  2'b00, 0);
    step("lumw_wait",     0, 0, 1, 0, 0, MW,  2'b00, 1);
    step("lumw_ack",      0, 0, 1, 1, 0, RUN, 2'b00, 1);
    step("lumw_idle",     0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("rst_lu_enter",  1, 0, 0, 0, 0, LU,  2'b00, 0);

    // Asynchronous reset in the middle of an LU stall
    @(negedge CLK);
    bus.LU_HAZ = 1'b0;
    RST = 1'b1;
    exp_q.push_back(mk("rst_mid_lu", RUN, 2'b00, 1'b0));
    -> ev_async;
    @(negedge CLK);
    RST = 1'b0;

    step("post_rst",      0, 0, 0, 0, 0, RUN, 2'b00, 0);
    step("halt_enter",    1, 1, 1, 0, 1, HLT, 2'b00, 0);
    step("halt_hold_lu",  1, 0, 0, 0, 0, HLT, 2'b00, 1);
    step("halt_hold_br",  0, 1, 1, 0, 0, HLT, 2'b00, 1);
    step("halt_hold_ack", 0, 0, 1, 1, 0, HLT, 2'b00, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
